// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx -- MCLK-domain I2S serializer.
//
// Accepts one stereo PCM pair per frame through a single-entry holding
// register and shifts it out as BCLK / LRCK / SDATA. A frame is 64 BCLK
// slots (32 per channel); one BCLK period is 2^MCLK_DIV_LOG2 MCLK cycles.
//
// Handshake: a pair is transferred on a rising MCLK_I edge where VALID_I and
// READY_O are both high. READY_O is high exactly when the holding register
// is empty, does not depend on VALID_I, and the source may change PCML_I /
// PCMR_I freely while no transfer is taking place.
//
// Ports
//   MCLK_I       in   master clock, all logic on its rising edge
//   ARESETN_I    in   asynchronous active-low reset
//   PCML_I       in   left sample  [DATA_WIDTH-1:0], two's complement
//   PCMR_I       in   right sample [DATA_WIDTH-1:0]
//   VALID_I      in   sample pair valid
//   READY_O      out  holding register empty
//   BCLK_O       out  bit clock
//   LRCK_O       out  word select
//   SDATA_O      out  serial data, MSB first
//   UNDERFLOW_O  out  one-cycle pulse when a frame starts with no sample
//
// Build option
//   PCM_I2S_TX_LJ_EN  defined: left-justified format, LRCK high = left.
//                     undefined: I2S format (one-slot data delay, LRCK low = left).
module pcm_i2s_tx #(
  parameter int DATA_WIDTH    = 32,
  parameter int MCLK_DIV_LOG2 = 1
) (
  input  logic                  MCLK_I,
  input  logic                  ARESETN_I,
  input  logic [DATA_WIDTH-1:0] PCML_I,
  input  logic [DATA_WIDTH-1:0] PCMR_I,
  input  logic                  VALID_I,
  output logic                  READY_O,
  output logic                  BCLK_O,
  output logic                  LRCK_O,
  output logic                  SDATA_O,
  output logic                  UNDERFLOW_O
);

  localparam int W   = MCLK_DIV_LOG2 + 6;
  localparam int PAD = 32 - DATA_WIDTH;

`ifdef PCM_I2S_TX_LJ_EN
  localparam logic LRCK_RST = 1'b1;
`else
  localparam logic LRCK_RST = 1'b0;
`endif

  logic [W-1:0]          cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic                  bclk_q, bclk_d;
  logic                  lrck_q, lrck_d;
  logic                  sdata_q, sdata_d;
  logic                  under_q, under_d;
  logic                  wrap, xfer;
  logic [5:0]            slot_d;
  logic [4:0]            bit_idx;
  logic [31:0]           l_just, r_just;

  assign cnt_d  = cnt_q + W'(1);
  assign wrap   = &cnt_q;
  assign xfer   = VALID_I & ~full_q;
  assign slot_d = cnt_d[W-1:MCLK_DIV_LOG2];

  // Outputs are registered from the *next* counter value so that in the
  // cycle the counter holds c the outputs already reflect c.
  always_comb begin
    full_d    = full_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    under_d   = 1'b0;
    if (wrap) begin
      if (full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        full_d    = 1'b0;
      end else begin
        frame_l_d = '0;
        frame_r_d = '0;
        under_d   = 1'b1;
      end
    end
    // A transfer on an empty-holding wrap lands in the holding register;
    // the frame starting now still transmits zeros.
    if (xfer) begin
      hold_l_d = PCML_I;
      hold_r_d = PCMR_I;
      full_d   = 1'b1;
    end
  end

  // Words are MSB-justified into 32 bits so that short words pad with zeros.
  assign l_just = 32'(frame_l_d) << PAD;
  assign r_just = 32'(frame_r_d) << PAD;

`ifdef PCM_I2S_TX_LJ_EN
  // Slot k carries bit 31-k of the justified word of its channel.
  assign bit_idx = ~slot_d[4:0];

  always_comb begin
    bclk_d  = cnt_d[MCLK_DIV_LOG2-1];
    lrck_d  = ~slot_d[5];
    sdata_d = slot_d[5] ? r_just[bit_idx] : l_just[bit_idx];
  end
`else
  logic lsb_q, lsb_d;

  // Slot k (1..32) carries left bit 32-k, slot 32+k carries right bit 32-k,
  // so both reduce to bit (-slot) mod 32. Right bit 0 spills into slot 0 of
  // the next frame; lsb_q keeps it because the frame register has already
  // been reloaded by then.
  assign bit_idx = 5'd0 - slot_d[4:0];

  always_comb begin
    lsb_d   = wrap ? ((PAD == 0) ? frame_r_q[0] : 1'b0) : lsb_q;
    bclk_d  = cnt_d[MCLK_DIV_LOG2-1];
    lrck_d  = slot_d[5];
    if (slot_d == 6'd0) begin
      sdata_d = lsb_d;
    end else if (slot_d <= 6'd32) begin
      sdata_d = l_just[bit_idx];
    end else begin
      sdata_d = r_just[bit_idx];
    end
  end

  always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
    if (!ARESETN_I) begin
      lsb_q <= 1'b0;
    end else begin
      lsb_q <= lsb_d;
    end
  end
`endif

  always_ff @(posedge MCLK_I or negedge ARESETN_I) begin
    if (!ARESETN_I) begin
      cnt_q     <= '0;
      full_q    <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      bclk_q    <= 1'b0;
      lrck_q    <= LRCK_RST;
      sdata_q   <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      under_q   <= under_d;
    end
  end

  assign READY_O     = ~full_q;
  assign BCLK_O      = bclk_q;
  assign LRCK_O      = lrck_q;
  assign SDATA_O     = sdata_q;
  assign UNDERFLOW_O = under_q;

endmodule
